// File: rtl/sram_pkg.sv
// sram_pkg: shared state/owner encodings and default widths for the SRAM port arbiter
package sram_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner select between fetch and data requests (round-robin under SRAM_ARB_RR_EN)
module sram_arb_pick
  import sram_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_owner_i,
  output logic   any_o,
  output owner_e win_o
);
  assign any_o = i_req_i | d_req_i;
`ifdef SRAM_ARB_RR_EN
  assign win_o = (i_req_i & d_req_i) ? ((last_owner_i == OWN_D) ? OWN_I : OWN_D)
               : (d_req_i ? OWN_D : OWN_I);
`else
  logic unused_last;
  assign unused_last = last_owner_i;
  assign win_o = d_req_i ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM engine between fetch and data ports; SRAM_ARB_RR_EN selects round-robin arbitration
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              eng_read_ce,
  output logic              eng_write_ce,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_wdata,
  input  logic [DATA_W-1:0] eng_rdata,
  input  logic              eng_fin,
  output logic              err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  owner_e own_q, own_d, win, last_own;
  logic any, wr, done;
  logic rce_q, rce_d, wce_q, wce_d, i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  sram_arb_pick u_pick (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_owner_i (last_own),
    .any_o        (any),
    .win_o        (win)
  );

`ifdef SRAM_ARB_RR_EN
  owner_e last_q, last_d;
  assign last_d   = (state_q == IDLE && any) ? win : last_q;
  assign last_own = last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= OWN_D;
    else     last_q <= last_d;
`else
  assign last_own = OWN_D;
`endif

  assign wr   = (win == OWN_D) & d_we;
  // fin wins over a timeout landing on the same edge, so the data is not lost
  assign done = eng_fin | (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rce_d     = rce_q;
    wce_d     = wce_q;
    err_d     = err_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: if (any) begin
        state_d = BUSY;
        own_d   = win;
        addr_d  = (win == OWN_D) ? d_addr : i_addr;
        wdata_d = (win == OWN_D) ? d_wdata : wdata_q;
        cnt_d   = '0;
        rce_d   = ~wr;
        wce_d   = wr;
      end
      BUSY: if (done) begin
        state_d   = GAP;
        rce_d     = 1'b0;
        wce_d     = 1'b0;
        err_d     = err_q | ~eng_fin;
        i_ack_d   = own_q == OWN_I;
        d_ack_d   = own_q == OWN_D;
        i_rdata_d = (eng_fin & rce_q & own_q == OWN_I) ? eng_rdata : i_rdata_q;
        d_rdata_d = (eng_fin & rce_q & own_q == OWN_D) ? eng_rdata : d_rdata_q;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      own_q     <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rce_q     <= 1'b0;
      wce_q     <= 1'b0;
      err_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rce_q     <= rce_d;
      wce_q     <= wce_d;
      err_q     <= err_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_stall      = i_req & ~i_ack_q;
  assign d_stall      = d_req & ~d_ack_q;
  assign eng_read_ce  = rce_q;
  assign eng_write_ce = wce_q;
  assign eng_addr     = addr_q;
  assign eng_wdata    = wdata_q;
  assign err          = err_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_sram_port_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req, i_ack, i_stall, d_req, d_we, d_ack, d_stall;
  logic eng_read_ce, eng_write_ce, eng_fin, err;
  logic [AW-1:0] i_addr, d_addr, eng_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, eng_wdata, eng_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .eng_read_ce(eng_read_ce), .eng_write_ce(eng_write_ce), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_fin(eng_fin), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int ce_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: one access record plus a gap flag; timing from the rules (grant edge, fin edge, one gap cycle)
  bit m_busy, m_gap, m_we, m_own, m_iack, m_dack, m_err, m_last;
  int m_n;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_irdata, m_drdata;

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_gap = 0; m_we = 0; m_own = 0; m_iack = 0; m_dack = 0; m_err = 0; m_last = 1;
      m_n = 0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    end else begin
      m_iack = 0;
      m_dack = 0;
      if (m_gap) m_gap = 0;
      else if (m_busy) begin
        m_n++;
        if (eng_fin || m_n == TO) begin
          if (!eng_fin) m_err = 1;
          else if (!m_we) begin
            if (m_own) m_drdata = eng_rdata;
            else m_irdata = eng_rdata;
          end
          if (m_own) m_dack = 1;
          else m_iack = 1;
          m_busy = 0;
          m_gap = 1;
        end
      end else if (i_req || d_req) begin
`ifdef SRAM_ARB_RR_EN
        m_own = (i_req && d_req) ? !m_last : d_req;
`else
        m_own = d_req;
`endif
        m_last = m_own;
        m_we = m_own && d_we;
        m_addr = m_own ? d_addr : i_addr;
        if (m_own) m_wdata = d_wdata;
        m_busy = 1;
        m_n = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("i_ack", i_ack, m_iack);
    chk("d_ack", d_ack, m_dack);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("read_ce", eng_read_ce, m_busy && !m_we);
    chk("write_ce", eng_write_ce, m_busy && m_we);
    chk("eng_addr", eng_addr, m_addr);
    chk("err", err, m_err);
    chk("i_stall", i_stall, i_req && !m_iack);
    chk("d_stall", d_stall, d_req && !m_dack);
    if (m_busy && m_we) chk("eng_wdata", eng_wdata, m_wdata);
  end

  task automatic wait_en(input string name);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = eng_read_ce | eng_write_ce;
    end
    chk({name, "_grant"}, seen, 1'b1);
    ce_cnt = int'(seen);
  endtask

  task automatic finish_acc(input int lat, input logic [DW-1:0] data);
    repeat (lat - 1) begin
      @(negedge clk);
      ce_cnt += int'(eng_read_ce | eng_write_ce);
    end
    eng_fin = 1'b1;
    eng_rdata = data;
    @(negedge clk);
    eng_fin = 1'b0;
  endtask

  initial #200000 begin
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fetch_first;
    logic [DW-1:0] prev;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    eng_fin = 0; eng_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_irdata", i_rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_ce", {eng_read_ce, eng_write_ce}, 2'b00);

    i_req = 1; i_addr = 20'h00010;
    wait_en("fetch");
    finish_acc(5, 32'hDEADBEEF);
    chk("fetch_ack", i_ack, 1'b1);
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_ce_cycles", ce_cnt, 5);
    i_req = 0;
    chk("fetch_stall", i_stall, 1'b0);
    @(negedge clk);
    chk("fetch_ack_pulse", i_ack, 1'b0);

    d_req = 1; d_we = 1; d_addr = 20'h00400; d_wdata = 32'h12345678;
    wait_en("dwr");
    chk("dwr_wdata", eng_wdata, 32'h12345678);
    chk("dwr_rce", eng_read_ce, 1'b0);
    finish_acc(3, 32'hBAD0BAD0);
    chk("dwr_ack", d_ack, 1'b1);
    chk("dwr_rdata", d_rdata, 32'h0);
    d_req = 0; d_we = 0;
    @(negedge clk);

    d_req = 1; d_addr = 20'h00022;
    wait_en("drd");
    finish_acc(2, 32'hA5A50F0F);
    chk("drd_rdata", d_rdata, 32'hA5A50F0F);
    d_req = 0;
    @(negedge clk);

    eng_fin = 1; eng_rdata = 32'h55;
    @(negedge clk);
    eng_fin = 0;
    chk("stray_fin_ack", {i_ack, d_ack}, 2'b00);

`ifdef SRAM_ARB_RR_EN
    fetch_first = 1;
`else
    fetch_first = 0;
`endif
    i_req = 1; d_req = 1; i_addr = 20'h00111; d_addr = 20'h00222;
    wait_en("tie1");
    chk("tie1_addr", eng_addr, fetch_first ? 20'h00111 : 20'h00222);
    chk("tie1_loser_stall", fetch_first ? d_stall : i_stall, 1'b1);
    finish_acc(2, 32'h11111111);
    chk("tie1_ack", fetch_first ? i_ack : d_ack, 1'b1);
    if (fetch_first) i_req = 0;
    else d_req = 0;
    wait_en("tie2");
    finish_acc(2, 32'h22222222);
    chk("tie2_ack", fetch_first ? d_ack : i_ack, 1'b1);
    i_req = 0; d_req = 0;
    @(negedge clk);

    prev = i_rdata;
    i_req = 1; i_addr = 20'h00333; ce_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_ack) break;
      ce_cnt += int'(eng_read_ce);
    end
    chk("to_ack", i_ack, 1'b1);
    chk("to_ce_cycles", ce_cnt, TO);
    chk("to_err", err, 1'b1);
    chk("to_rdata", i_rdata, prev);
    i_req = 0;
    @(negedge clk);
    d_req = 1; d_addr = 20'h00044;
    wait_en("after_to");
    finish_acc(3, 32'h0BADF00D);
    chk("after_to_rdata", d_rdata, 32'h0BADF00D);
    chk("err_sticky", err, 1'b1);
    d_req = 0;
    @(negedge clk);

    i_req = 1; i_addr = 20'h00555;
    wait_en("rst_busy");
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_rce", eng_read_ce, 1'b0);
    chk("rst_mid_ack", i_ack, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    @(negedge clk);
    rst = 0;
    wait_en("regrant");
    finish_acc(3, 32'h00000077);
    chk("regrant_ack", i_ack, 1'b1);
    chk("regrant_rdata", i_rdata, 32'h77);
    i_req = 0;
    @(negedge clk);

    d_req = 1; d_we = 1; d_addr = 20'h00666; d_wdata = 32'h66;
    wait_en("drop");
    d_req = 0;
    finish_acc(4, 32'h0);
    chk("drop_ack", d_ack, 1'b1);
    d_we = 0;
    repeat (5) @(negedge clk);
    chk("drop_no_regrant", {eng_read_ce, eng_write_ce}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
